// File: rtl/light_show_pkg.sv
// Shared constants for the light-show routine scheduler: bus layout, blank pattern, FSM encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package light_show_pkg;

   localparam int BUS_WIDTH     = 46;
   localparam int ROUTINE_COUNT = 4;
   localparam int SEL_W         = $clog2(ROUTINE_COUNT);

   // OutputBus field positions
   localparam int RED_MSB   = 45;
   localparam int RED_LSB   = 36;
   localparam int GREEN_MSB = 35;
   localparam int GREEN_LSB = 28;
   localparam int HEX_MSB   = 27;
   localparam int HEX_LSB   = 0;

   // LEDs off and every active-low segment driven high (dark digits)
   function automatic logic [BUS_WIDTH-1:0] make_blank_bus();
      logic [BUS_WIDTH-1:0] b;
      b                    = '0;
      b[RED_MSB:RED_LSB]   = '0;
      b[GREEN_MSB:GREEN_LSB] = '0;
      b[HEX_MSB:HEX_LSB]   = '1;
      return b;
   endfunction

   localparam logic [BUS_WIDTH-1:0] BLANK_BUS = make_blank_bus();

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_BLANK = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes the raw active-low advance button and debounces it on Tick.
// Latency: 2 Clocks of synchronization plus DEBOUNCE_TICKS stable Ticks before Press.
// Backpressure: none; Press is a single-Clock strobe and is never held or queued.
module button_debouncer
   import light_show_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 3
)
(
   input  logic Clock,
   input  logic ResetN,
   input  logic Tick,
   input  logic AdvanceN,
   output logic Press
);

   localparam int CNT_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic [CNT_W-1:0] r_stable_cnt;
   logic             w_differs;
   logic             w_accept;

   assign w_differs = (r_sync2 != r_level);
   // The Tick on which the synchronized value has differed for the full count
   assign w_accept  = Tick && w_differs && (r_stable_cnt == CNT_LAST);
   // Falling edge of the debounced level, flagged in the Clock the level flips
   assign Press     = w_accept && r_level;

   // Two-flop synchronizer; released (1) out of reset
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= AdvanceN;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive differing Ticks; any agreeing Tick restarts the count
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_stable_cnt <= '0;
         r_level      <= 1'b1;
      end else if (Tick) begin
         if (!w_differs) begin
            r_stable_cnt <= '0;
         end else if (w_accept) begin
            r_stable_cnt <= '0;
            r_level      <= r_sync2;
         end else begin
            r_stable_cnt <= r_stable_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/routine_scheduler.sv
// Cycles through four light-show routines, pacing them with Tick and blanking the display between routines.
// Latency: OutputBus follows RoutineBus[RoutineSel] by one Clock; an advance enters BLANK on the next Clock.
// Backpressure: none; presses during BLANK/LOAD are dropped and routines must obey Tick and RoutineRestart.
module routine_scheduler
   import light_show_pkg::*;
#(
   parameter int CLK_DIV        = 4,
   parameter int DWELL_TICKS    = 64,
   parameter int BLANK_TICKS    = 4,
   parameter int DEBOUNCE_TICKS = 3
)
(
   input  logic                 Clock,
   input  logic                 ResetN,
   input  logic                 AdvanceN,
   input  logic                 AutoMode,
   input  logic [BUS_WIDTH-1:0] RoutineBus0,
   input  logic [BUS_WIDTH-1:0] RoutineBus1,
   input  logic [BUS_WIDTH-1:0] RoutineBus2,
   input  logic [BUS_WIDTH-1:0] RoutineBus3,
   output logic                 Tick,
   output logic                 RoutineRestart,
   output logic [SEL_W-1:0]     RoutineSel,
   output logic [BUS_WIDTH-1:0] OutputBus
);

   localparam int PS_W = $clog2(CLK_DIV);
   localparam int DW_W = $clog2(DWELL_TICKS + 1);
   localparam int BL_W = $clog2(BLANK_TICKS + 1);

   localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(CLK_DIV - 1);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_TICKS - 1);
   localparam logic [BL_W-1:0]  BLANK_LAST = BL_W'(BLANK_TICKS - 1);
   localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(ROUTINE_COUNT - 1);

   logic [PS_W-1:0]      r_prescale;
   state_t               r_state;
   state_t               w_next_state;
   logic [DW_W-1:0]      r_dwell;
   logic [BL_W-1:0]      r_blank;
   logic [SEL_W-1:0]     r_sel;
   logic [BUS_WIDTH-1:0] r_out;
   logic [BUS_WIDTH-1:0] w_out_next;
   logic [BUS_WIDTH-1:0] w_bus [ROUTINE_COUNT];
   logic                 w_tick;
   logic                 w_press;
   logic                 w_expire;
   logic                 w_blank_done;
   logic                 w_restart;

   assign w_bus[0] = RoutineBus0;
   assign w_bus[1] = RoutineBus1;
   assign w_bus[2] = RoutineBus2;
   assign w_bus[3] = RoutineBus3;

   assign w_tick       = (r_prescale == PS_LAST);
   assign w_expire     = (r_state == ST_RUN) && w_tick && AutoMode && (r_dwell == DWELL_LAST);
   assign w_blank_done = (r_state == ST_BLANK) && w_tick && (r_blank == BLANK_LAST);

   assign Tick           = w_tick;
   assign RoutineRestart = w_restart;
   assign RoutineSel     = r_sel;
   assign OutputBus      = r_out;

   button_debouncer #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
   ) u_debouncer (
      .Clock    (Clock),
      .ResetN   (ResetN),
      .Tick     (w_tick),
      .AdvanceN (AdvanceN),
      .Press    (w_press)
   );

   // Free-running prescaler 0..CLK_DIV-1; restarts from 0 after reset
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_prescale <= '0;
      end else if (w_tick) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + PS_W'(1);
      end
   end

   // State register
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: a press and a dwell expiry together still make one advance
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_RUN:   if (w_expire || w_press) w_next_state = ST_BLANK;
         ST_BLANK: if (w_blank_done)        w_next_state = ST_LOAD;
         ST_LOAD:  w_next_state = ST_RUN;
         default:  w_next_state = ST_RUN;
      endcase
   end

   // Outputs decoded from state: restart strobe in LOAD, live routine only in RUN
   always_comb begin
      w_restart  = 1'b0;
      w_out_next = BLANK_BUS;
      case (r_state)
         ST_RUN:  w_out_next = w_bus[r_sel];
         ST_LOAD: w_restart  = 1'b1;
         default: w_restart  = 1'b0;
      endcase
   end

   // Dwell/blank counters and routine select; LOAD clears counters and advances the select
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_dwell <= '0;
         r_blank <= '0;
         r_sel   <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_tick && AutoMode) r_dwell <= r_dwell + DW_W'(1);
            end
            ST_BLANK: begin
               if (w_tick) r_blank <= r_blank + BL_W'(1);
            end
            ST_LOAD: begin
               r_dwell <= '0;
               r_blank <= '0;
               r_sel   <= (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
            end
            default: r_dwell <= r_dwell;
         endcase
      end
   end

   // Registered display output
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_out <= BLANK_BUS;
      end else begin
         r_out <= w_out_next;
      end
   end

endmodule
